sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Pipelined, parametrised sprite layer for the VGA path. Replaces per-sprite combinational compare/mux with an N-channel, fixed-priority compositor.
- Sits between the VGA controller (DrawX/DrawY) and the VGA DACs.
- Sprite positions and palette are frame-synchronised through shadow registers.
- Bitmap rows come from an external synchronous sprite ROM.
- Adds per-frame collision reporting between channel 0 (player) and all other channels.

Parameters:
- NUM_SPRITES, 5, number of sprite channels; channel 0 = player, highest priority.
- SPRITE_SIZE, 16, sprite width/height in pixels; power of two, 4..64.
- COORD_W, 10, width of DrawX/DrawY and sprite coordinates.
- COLOR_W, 8, bits per colour component.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous reset, active-low
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- pix_valid  in  1  DrawX/DrawY/bg_rgb valid this cycle
- DrawX  in  COORD_W  current pixel column
- DrawY  in  COORD_W  current pixel row
- bg_rgb  in  3*COLOR_W  background colour {R,G,B} aligned with DrawX/DrawY
- spr_x  in  NUM_SPRITES*COORD_W  top-left X per channel, channel k at [k*COORD_W +: COORD_W]; sampled into shadow every cycle
- spr_y  in  NUM_SPRITES*COORD_W  top-left Y per channel; packed like spr_x
- spr_en  in  NUM_SPRITES  channel enable; shadowed like spr_x
- spr_mirror  in  NUM_SPRITES  per-channel horizontal flip (optional feature only)
- pal_we  in  1  palette write strobe
- pal_idx  in  $clog2(NUM_SPRITES)  palette entry to write
- pal_rgb  in  3*COLOR_W  palette colour
- row_addr  out  NUM_SPRITES*$clog2(SPRITE_SIZE)  per-channel ROM row index, combinational from DrawY
- row_data  in  NUM_SPRITES*SPRITE_SIZE  per-channel ROM row, valid one cycle after row_addr; bit SPRITE_SIZE-1 = leftmost pixel
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  composited colour
- rgb_valid  out  1  pix_valid delayed by 2
- coll_flags  out  NUM_SPRITES  bit k = channel 0 overlapped opaque channel k during the previous frame; bit 0 always 0
- coll_valid  out  1  one-cycle pulse when coll_flags updates

Behaviour:
- Reset (Reset_n low at edge):
  - All outputs 0; coll_flags 0.
  - Shadow and active positions 0; enables 0.
  - All palette entries 24'hFFFFFF for COLOR_W=8; all-ones generally.
  - Collision accumulator and pipeline valids cleared.
  - Reset asserted mid-frame drops in-flight pixels; rgb_valid is 0 the cycle after.
- Shadow/commit:
  - spr_x/spr_y/spr_en are registered into shadow every cycle.
  - pal_we writes the shadow palette entry; pal_idx >= NUM_SPRITES is ignored.
  - On frame_start, shadow is copied to active. A pal_we in the same cycle is included in the commit.
  - Compositing uses active values only. A pixel presented in the frame_start cycle uses the pre-commit active set.
- Stage 0 (cycle t):
  - Hit_k = en_k && DrawX >= x_k && DrawX < x_k+SPRITE_SIZE, with the same test on Y.
  - Compares use COORD_W+1 bits, so no wrap: a sprite at x=1020 with size 16 covers 1020..1023 only.
  - row_addr_k = (DrawY - y_k) low bits; drives 0 when no Y hit.
  - Register hit_k, col_k = (DrawX - x_k) low bits, bg_rgb, pix_valid.
- Stage 1 (cycle t+1):
  - opaque_k = hit_k && row_data_k[SPRITE_SIZE-1-col_k].
  - Lowest-index opaque channel wins and its palette colour is output; if none are opaque, bg_rgb is output.
  - Registered to VGA_* and rgb_valid at t+2.
  - Total latency is exactly 2 cycles; one pixel per cycle, no stalls.
  - When pix_valid=0, VGA_* = 0 and rgb_valid = 0.
- Collision:
  - Each valid stage-1 pixel with opaque_0 && opaque_k (k>=1) sets acc[k].
  - On frame_start: coll_flags <= acc | current-cycle hits; acc cleared; coll_valid=1 next cycle.
  - The flags persist until the next frame_start.

Optional Feature:
- SPRITE_MIRROR_EN defined: channel k with active mirror bit set samples row bit col_k instead of SPRITE_SIZE-1-col_k. The mirror bit is shadowed and committed like spr_en.
- Not defined: spr_mirror is ignored and no mirror registers exist.

Test Plan:
- Reset, then ch1 at (100,100), en=1, frame_start; row_data_1 all ones; DrawX=105, DrawY=108 -> row_addr_1=8; 2 cycles later VGA = palette[1] = FFFFFF, rgb_valid=1.
- ch0 and ch2 both at (50,50), both rows all ones, palette[0]=00FF00, palette[2]=FF5F5F -> output 00FF00. Set row_data_0=0 -> output FF5F5F.
- Write pal_idx=3, pal_rgb=FFB851 with no frame_start -> ch3 pixel still FFFFFF. After frame_start -> FFB851. Write with pal_idx=7 -> no change.
- ch0 at (200,200) overlapping opaque ch4 at (210,200) for one pixel -> at next frame_start coll_flags=5'b10000, coll_valid pulses one cycle. Following frame with no overlap -> 0.
- ch1 at x=1020, size 16, DrawX=1023 -> hit. DrawX=3 -> no hit (bg_rgb passes through). Reset_n low mid-stream -> rgb_valid=0 on the next cycle.
- SPRITE_MIRROR_EN, mirror_1=1, row_data_1=16'h8000, col 0 -> background; col 15 -> palette[1].

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: N-channel, fixed-priority sprite layer for the VGA path.
// Two-cycle pipeline: stage 0 does the position compares and drives the ROM row
// address; stage 1 picks the opaque channel with the lowest index and registers
// the colour. Positions, enables and palette are held in shadow registers and
// copied to the active set on frame_start. Channel 0 (player) overlap with any
// other opaque channel is accumulated per frame and reported in coll_flags.
// Optional build macro: SPRITE_MIRROR_EN adds per-channel horizontal flip.
module sprite_compositor #(
  parameter int NUM_SPRITES = 5,
  parameter int SPRITE_SIZE = 16,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 8
) (
  input  logic                                    Clk,
  input  logic                                    Reset_n,
  input  logic                                    frame_start,
  input  logic                                    pix_valid,
  input  logic [COORD_W-1:0]                      DrawX,
  input  logic [COORD_W-1:0]                      DrawY,
  input  logic [3*COLOR_W-1:0]                    bg_rgb,
  input  logic [NUM_SPRITES*COORD_W-1:0]          spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]          spr_y,
  input  logic [NUM_SPRITES-1:0]                  spr_en,
  input  logic [NUM_SPRITES-1:0]                  spr_mirror,
  input  logic                                    pal_we,
  input  logic [$clog2(NUM_SPRITES)-1:0]          pal_idx,
  input  logic [3*COLOR_W-1:0]                    pal_rgb,
  output logic [NUM_SPRITES*$clog2(SPRITE_SIZE)-1:0] row_addr,
  input  logic [NUM_SPRITES*SPRITE_SIZE-1:0]      row_data,
  output logic [COLOR_W-1:0]                      VGA_R,
  output logic [COLOR_W-1:0]                      VGA_G,
  output logic [COLOR_W-1:0]                      VGA_B,
  output logic                                    rgb_valid,
  output logic [NUM_SPRITES-1:0]                  coll_flags,
  output logic                                    coll_valid
);

  localparam int LOG   = $clog2(SPRITE_SIZE);
  localparam int RGB_W = 3 * COLOR_W;
  localparam logic [COORD_W:0] SIZE_W = (COORD_W + 1)'(SPRITE_SIZE);

  // Shadow (written any time) and active (used by the pipeline) state
  logic [NUM_SPRITES*COORD_W-1:0] sh_x, sh_y, act_x, act_y;
  logic [NUM_SPRITES-1:0]         sh_en, act_en;
  logic [RGB_W-1:0]               sh_pal  [NUM_SPRITES];
  logic [RGB_W-1:0]               act_pal [NUM_SPRITES];
`ifdef SPRITE_MIRROR_EN
  logic [NUM_SPRITES-1:0]         sh_mirror, act_mirror;
`else
  logic unused_mirror;
  assign unused_mirror = ^spr_mirror;
`endif

  // Capture shadow state every cycle and commit it to the active set at frame start
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_en  <= '0;
      act_x  <= '0;
      act_y  <= '0;
      act_en <= '0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
        sh_pal[k]  <= '1;
        act_pal[k] <= '1;
      end
`ifdef SPRITE_MIRROR_EN
      sh_mirror  <= '0;
      act_mirror <= '0;
`endif
    end else begin
      sh_x  <= spr_x;
      sh_y  <= spr_y;
      sh_en <= spr_en;
`ifdef SPRITE_MIRROR_EN
      sh_mirror <= spr_mirror;
`endif
      for (int k = 0; k < NUM_SPRITES; k++) begin
        if (pal_we && (32'(pal_idx) == k))
          sh_pal[k] <= pal_rgb;
      end
      if (frame_start) begin
        act_x  <= sh_x;
        act_y  <= sh_y;
        act_en <= sh_en;
`ifdef SPRITE_MIRROR_EN
        act_mirror <= sh_mirror;
`endif
        // A palette write landing in the commit cycle must not be lost
        for (int k = 0; k < NUM_SPRITES; k++)
          act_pal[k] <= (pal_we && (32'(pal_idx) == k)) ? pal_rgb : sh_pal[k];
      end
    end
  end

  // ---- stage 0: position compare, ROM row address ----
  logic [NUM_SPRITES-1:0]     hit_p0;
  logic [NUM_SPRITES*LOG-1:0] col_p0;
  logic [COORD_W:0]           draw_x_w, draw_y_w;

  assign draw_x_w = {1'b0, DrawX};
  assign draw_y_w = {1'b0, DrawY};

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_stage0
    logic [COORD_W:0] x_w, y_w;
    logic             in_x, in_y;
    // One extra bit keeps x+SIZE from wrapping back to column 0
    assign x_w  = {1'b0, act_x[g*COORD_W +: COORD_W]};
    assign y_w  = {1'b0, act_y[g*COORD_W +: COORD_W]};
    assign in_x = (draw_x_w >= x_w) && (draw_x_w < x_w + SIZE_W);
    assign in_y = act_en[g] && (draw_y_w >= y_w) && (draw_y_w < y_w + SIZE_W);
    assign hit_p0[g] = in_x && in_y;
    assign col_p0[g*LOG +: LOG] = DrawX[LOG-1:0] - act_x[g*COORD_W +: LOG];
    assign row_addr[g*LOG +: LOG] =
      in_y ? (DrawY[LOG-1:0] - act_y[g*COORD_W +: LOG]) : '0;
  end

  logic                       vld_p1;
  logic [NUM_SPRITES-1:0]     hit_p1;
  logic [NUM_SPRITES*LOG-1:0] col_p1;
  logic [RGB_W-1:0]           bg_p1;

  // Stage 0 -> 1 valid; cleared on reset so in-flight pixels are dropped
  always_ff @(posedge Clk) begin
    if (!Reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= pix_valid;
  end

  // Stage 0 -> 1 data; qualified by vld_p1 downstream so no reset needed
  always_ff @(posedge Clk) begin
    hit_p1 <= hit_p0;
    col_p1 <= col_p0;
    bg_p1  <= bg_rgb;
  end

  // ---- stage 1: opacity lookup, priority select ----
  logic [NUM_SPRITES-1:0] opaque_p1;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_stage1
    logic [SPRITE_SIZE-1:0] row_k;
    logic [LOG-1:0]         bit_sel;
    assign row_k = row_data[g*SPRITE_SIZE +: SPRITE_SIZE];
    // Leftmost pixel is the MSB, so column c maps to bit SIZE-1-c == ~c
`ifdef SPRITE_MIRROR_EN
    assign bit_sel = act_mirror[g] ? col_p1[g*LOG +: LOG] : ~col_p1[g*LOG +: LOG];
`else
    assign bit_sel = ~col_p1[g*LOG +: LOG];
`endif
    assign opaque_p1[g] = hit_p1[g] && row_k[bit_sel];
  end

  logic [RGB_W-1:0] win_rgb_p1;

  // Fixed priority: walk from highest index down so channel 0 wins last
  always_comb begin
    win_rgb_p1 = bg_p1;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (opaque_p1[k]) win_rgb_p1 = act_pal[k];
    end
  end

  logic [NUM_SPRITES-1:0] coll_now_p1;

  // Player overlap with any other opaque channel on a valid pixel
  always_comb begin
    coll_now_p1 = '0;
    if (vld_p1 && opaque_p1[0])
      coll_now_p1 = {opaque_p1[NUM_SPRITES-1:1], 1'b0};
  end

  // ---- stage 1 -> output register ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      rgb_valid             <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= vld_p1 ? win_rgb_p1 : '0;
      rgb_valid             <= vld_p1;
    end
  end

  logic [NUM_SPRITES-1:0] coll_acc;

  // Per-frame collision accumulator, published and cleared at frame start
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      coll_acc   <= '0;
      coll_flags <= '0;
      coll_valid <= 1'b0;
    end else if (frame_start) begin
      coll_flags <= coll_acc | coll_now_p1;
      coll_acc   <= '0;
      coll_valid <= 1'b1;
    end else begin
      coll_acc   <= coll_acc | coll_now_p1;
      coll_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed testbench for sprite_compositor (default parameters).
module tb_sprite_compositor;

  localparam int N   = 5;
  localparam int S   = 16;
  localparam int CW  = 10;
  localparam int LOG = 4;
  localparam int IW  = 3;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            frame_start = 1'b0;
  logic            pix_valid = 1'b0;
  logic [CW-1:0]   DrawX = '0;
  logic [CW-1:0]   DrawY = '0;
  logic [23:0]     bg_rgb = 24'h123456;
  logic [N*CW-1:0] spr_x = '0;
  logic [N*CW-1:0] spr_y = '0;
  logic [N-1:0]    spr_en = '0;
  logic [N-1:0]    spr_mirror = '0;
  logic            pal_we = 1'b0;
  logic [IW-1:0]   pal_idx = '0;
  logic [23:0]     pal_rgb = '0;
  wire  [N*LOG-1:0] row_addr;
  logic [N*S-1:0]  row_data = '0;
  wire  [7:0]      VGA_R, VGA_G, VGA_B;
  wire             rgb_valid;
  wire  [N-1:0]    coll_flags;
  wire             coll_valid;

  int total = 0;
  int bad   = 0;

  wire [23:0]    vga   = {VGA_R, VGA_G, VGA_B};
  wire [LOG-1:0] row_1 = row_addr[LOG +: LOG];

  sprite_compositor #(
    .NUM_SPRITES(N), .SPRITE_SIZE(S), .COORD_W(CW), .COLOR_W(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY), .bg_rgb(bg_rgb),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_mirror(spr_mirror),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .row_addr(row_addr), .row_data(row_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .rgb_valid(rgb_valid),
    .coll_flags(coll_flags), .coll_valid(coll_valid)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic place(input int k, input logic [CW-1:0] x, input logic [CW-1:0] y);
    spr_x[k*CW +: CW] = x;
    spr_y[k*CW +: CW] = y;
  endtask

  task automatic set_row(input int k, input logic [S-1:0] v);
    row_data[k*S +: S] = v;
  endtask

  // one cycle for the shadow to capture inputs, then the frame_start pulse
  task automatic commit();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic write_pal(input logic [IW-1:0] idx, input logic [23:0] rgb);
    pal_idx = idx;
    pal_rgb = rgb;
    pal_we  = 1'b1;
    tick();
    pal_we  = 1'b0;
  endtask

  // present a pixel and wait out the 2-cycle latency
  task automatic show(input logic [CW-1:0] x, input logic [CW-1:0] y);
    DrawX = x;
    DrawY = y;
    pix_valid = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    total++; if (vga !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h want=%h", vga, 24'h0); end
    total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL reset_rgb_valid got=%b want=0", rgb_valid); end
    total++; if (coll_flags !== 5'b0) begin bad++; $display("FAIL reset_coll_flags got=%b want=00000", coll_flags); end
    total++; if (coll_valid !== 1'b0) begin bad++; $display("FAIL reset_coll_valid got=%b want=0", coll_valid); end
    total++; if (row_addr !== '0) begin bad++; $display("FAIL reset_row_addr got=%h want=0", row_addr); end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    place(1, 10'd100, 10'd100);
    spr_en = 5'b00010;
    commit();
    set_row(1, 16'hFFFF);
    DrawX = 10'd105;
    DrawY = 10'd108;
    pix_valid = 1'b1;
    #1;
    total++; if (row_1 !== 4'd8) begin bad++; $display("FAIL basic_row_addr got=%0d want=8", row_1); end
    tick();
    tick();
    total++; if (vga !== 24'hFFFFFF) begin bad++; $display("FAIL basic_rgb got=%h want=FFFFFF", vga); end
    total++; if (rgb_valid !== 1'b1) begin bad++; $display("FAIL basic_rgb_valid got=%b want=1", rgb_valid); end
    pix_valid = 1'b0;
    tick();
    tick();
    total++; if (vga !== 24'h0) begin bad++; $display("FAIL idle_rgb got=%h want=000000", vga); end
    total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL idle_rgb_valid got=%b want=0", rgb_valid); end
  endtask

  task automatic test_priority();
    write_pal(3'd0, 24'h00FF00);
    write_pal(3'd2, 24'hFF5F5F);
    place(0, 10'd50, 10'd50);
    place(2, 10'd50, 10'd50);
    spr_en = 5'b00111;
    commit();
    set_row(0, 16'hFFFF);
    set_row(2, 16'hFFFF);
    show(10'd55, 10'd55);
    total++; if (vga !== 24'h00FF00) begin bad++; $display("FAIL prio_ch0 got=%h want=00FF00", vga); end
    set_row(0, 16'h0000);
    tick();
    tick();
    total++; if (vga !== 24'hFF5F5F) begin bad++; $display("FAIL prio_ch2 got=%h want=FF5F5F", vga); end
    pix_valid = 1'b0;
  endtask

  task automatic test_palette_commit();
    place(3, 10'd300, 10'd300);
    spr_en = 5'b01111;
    commit();
    set_row(3, 16'hFFFF);
    write_pal(3'd3, 24'hFFB851);
    show(10'd305, 10'd305);
    total++; if (vga !== 24'hFFFFFF) begin bad++; $display("FAIL pal_precommit got=%h want=FFFFFF", vga); end
    commit();
    tick();
    tick();
    total++; if (vga !== 24'hFFB851) begin bad++; $display("FAIL pal_commit got=%h want=FFB851", vga); end
    write_pal(3'd7, 24'h000000);
    commit();
    tick();
    tick();
    total++; if (vga !== 24'hFFB851) begin bad++; $display("FAIL pal_idx7 got=%h want=FFB851", vga); end
    pal_idx = 3'd3;
    pal_rgb = 24'hABCDEF;
    pal_we = 1'b1;
    frame_start = 1'b1;
    tick();
    pal_we = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    total++; if (vga !== 24'hABCDEF) begin bad++; $display("FAIL pal_same_cycle got=%h want=ABCDEF", vga); end
    pix_valid = 1'b0;
  endtask

  task automatic test_collision();
    pix_valid = 1'b0;
    place(0, 10'd200, 10'd200);
    place(4, 10'd210, 10'd200);
    spr_en = 5'b10001;
    set_row(0, 16'hFFFF);
    set_row(4, 16'hFFFF);
    commit();
    commit();
    DrawX = 10'd205; DrawY = 10'd200; pix_valid = 1'b1;
    tick();
    DrawX = 10'd210;
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++; if (coll_flags !== 5'b10000) begin bad++; $display("FAIL coll_flags got=%b want=10000", coll_flags); end
    total++; if (coll_valid !== 1'b1) begin bad++; $display("FAIL coll_valid_pulse got=%b want=1", coll_valid); end
    tick();
    total++; if (coll_valid !== 1'b0) begin bad++; $display("FAIL coll_valid_drop got=%b want=0", coll_valid); end
    total++; if (coll_flags !== 5'b10000) begin bad++; $display("FAIL coll_flags_hold got=%b want=10000", coll_flags); end
    DrawX = 10'd205; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++; if (coll_flags !== 5'b00000) begin bad++; $display("FAIL coll_clear got=%b want=00000", coll_flags); end
    total++; if (coll_valid !== 1'b1) begin bad++; $display("FAIL coll_valid_pulse2 got=%b want=1", coll_valid); end
  endtask

  task automatic test_edge_and_reset();
    place(1, 10'd1020, 10'd400);
    spr_en = 5'b00010;
    set_row(1, 16'hFFFF);
    commit();
    bg_rgb = 24'h123456;
    DrawX = 10'd1023; DrawY = 10'd405; pix_valid = 1'b1;
    #1;
    total++; if (row_1 !== 4'd5) begin bad++; $display("FAIL edge_row_addr got=%0d want=5", row_1); end
    tick();
    tick();
    total++; if (vga !== 24'hFFFFFF) begin bad++; $display("FAIL edge_hit got=%h want=FFFFFF", vga); end
    show(10'd3, 10'd405);
    total++; if (vga !== 24'h123456) begin bad++; $display("FAIL edge_nowrap got=%h want=123456", vga); end
    DrawY = 10'd50;
    #1;
    total++; if (row_1 !== 4'd0) begin bad++; $display("FAIL row_addr_noy got=%0d want=0", row_1); end
    show(10'd1023, 10'd405);
    Reset_n = 1'b0;
    tick();
    total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", rgb_valid); end
    total++; if (vga !== 24'h0) begin bad++; $display("FAIL midreset_rgb got=%h want=000000", vga); end
    Reset_n = 1'b1;
    pix_valid = 1'b0;
    tick();
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror();
    place(1, 10'd100, 10'd100);
    spr_en = 5'b00010;
    spr_mirror = 5'b00010;
    set_row(1, 16'h8000);
    commit();
    show(10'd100, 10'd100);
    total++; if (vga !== 24'h123456) begin bad++; $display("FAIL mirror_col0 got=%h want=123456", vga); end
    show(10'd115, 10'd100);
    total++; if (vga !== 24'hFFFFFF) begin bad++; $display("FAIL mirror_col15 got=%h want=FFFFFF", vga); end
    pix_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_palette_commit();
    test_collision();
    test_edge_and_reset();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
